// File: rtl/axis_tx_pkg.sv
// Shared types and sizing helpers for the AXI-Stream FIFO transmitter.
package axis_tx_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Bits needed to encode values 0 .. v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_transmitter_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is presented combinationally.
module sync_fifo
    import axis_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_W + 1,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_ready = (count < CNT_W'(DEPTH));
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_en && (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_fifo_transmitter.sv
// Buffered AXI-Stream transmitter; define AXIS_TX_PACKET_MODE_EN for store-and-forward.
module axis_fifo_transmitter
    import axis_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              oversize_err
);

    tx_state_t     state;
    logic [DATA_W:0] head;
    logic          rd_fire;
    logic          start_ok;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_data  ({wr_last, wr_data}),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_en    (rd_fire),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign m_axis_tdata  = head[DATA_W-1:0];
    assign m_axis_tlast  = head[DATA_W];
    assign m_axis_tvalid = (state == SEND) && (fifo_count != '0);
    assign rd_fire       = m_axis_tvalid && m_axis_tready;

`ifdef AXIS_TX_PACKET_MODE_EN
    logic [CNT_W-1:0] pkt_count;
    logic             wr_fire;
    logic             pkt_in;
    logic             pkt_out;
    logic             full_no_pkt;

    assign wr_fire     = wr_valid && wr_ready;
    assign pkt_in      = wr_fire && wr_last;
    assign pkt_out     = rd_fire && m_axis_tlast;
    // A full FIFO holding no complete packet can never start; fall back to cut-through.
    assign full_no_pkt = (fifo_count == CNT_W'(DEPTH)) && (pkt_count == '0);
    assign start_ok    = (pkt_count != '0) || full_no_pkt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count    <= '0;
            oversize_err <= 1'b0;
        end else begin
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase
            if (full_no_pkt) oversize_err <= 1'b1;
        end
    end
`else
    assign start_ok     = (fifo_count != '0);
    assign oversize_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable && start_ok) state <= SEND;
                SEND:    if (rd_fire && m_axis_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_fifo_transmitter.sv
// Randomized and directed checks of axis_fifo_transmitter against a queue-based reference.
module tb_axis_fifo_transmitter;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 3;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [CW-1:0] fifo_count;
    logic          oversize_err;

    int n_checks;
    int n_fail;
    int beats;

    // Reference: buffered words {last,data}, whether a packet is in flight, sticky overflow flag.
    logic [DW:0] q[$];
    bit          in_pkt;
    bit          ovf;

    axis_fifo_transmitter #(
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .fifo_count    (fifo_count),
        .oversize_err  (oversize_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int n_pkts();
        int n;
        n = 0;
        foreach (q[i]) if (q[i][DW]) n++;
        return n;
    endfunction

    // Called at a negedge with inputs already driven: check outputs, advance one clock.
    task automatic step();
        bit          exp_tv;
        bit          wr_fire;
        bit          rd_fire;
        bit          start_ok;
        logic [DW:0] head;
        exp_tv = in_pkt && (q.size() != 0);
        check("tvalid", 32'(tvalid), 32'(exp_tv));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("wr_ready", 32'(wr_ready), 32'(q.size() < DEP));
        check("oversize_err", 32'(oversize_err), 32'(ovf));
        if (exp_tv) begin
            head = q[0];
            check("tdata", 32'(tdata), 32'(head[DW-1:0]));
            check("tlast", 32'(tlast), 32'(head[DW]));
        end
        wr_fire = wr_valid && (q.size() < DEP);
        rd_fire = exp_tv && tready;
`ifdef AXIS_TX_PACKET_MODE_EN
        start_ok = (n_pkts() != 0) || (q.size() == DEP);
`else
        start_ok = (q.size() != 0);
`endif
        @(posedge clk);
        if (reset) begin
            q.delete();
            in_pkt = 1'b0;
            ovf    = 1'b0;
        end else begin
`ifdef AXIS_TX_PACKET_MODE_EN
            if (q.size() == DEP && n_pkts() == 0) ovf = 1'b1;
`endif
            if (!in_pkt) begin
                if (enable && start_ok) in_pkt = 1'b1;
            end else if (rd_fire && q[0][DW]) begin
                in_pkt = 1'b0;
            end
            if (rd_fire) begin
                void'(q.pop_front());
                beats++;
            end
            if (wr_fire) q.push_back({wr_last, wr_data});
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int b0;
        n_checks = 0;
        n_fail   = 0;
        beats    = 0;
        in_pkt   = 1'b0;
        ovf      = 1'b0;
        reset    = 1'b1;
        enable   = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        wr_valid = 1'b0;
        tready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        idle(1);

        // Single packet, cut-through latency and ordering
        enable = 1'b1;
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b1);
        idle(6);

        // Backpressure pattern 1,0,0,1,...
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tready = (i % 3 == 0);
            step();
        end
        tready = 1'b1;
        idle(4);

        // Full and pointer wrap
        for (int r = 0; r < 3; r++) begin
            enable = 1'b0;
            for (int i = 0; i < 5; i++) wr(DW'(8'hA0 + r * 16 + i), (i == 3));
            check("full_wr_ready", 32'(wr_ready), 32'd0);
            check("full_count", 32'(fifo_count), 32'(DEP));
            enable = 1'b1;
            idle(8);
        end

        // Enable dropped mid-packet; next packet waits for enable
        enable = 1'b1;
        for (int i = 0; i < 4; i++) wr(DW'(8'h40 + i), (i == 3));
        enable = 1'b0;
        idle(6);
        wr(8'h50, 1'b0);
        wr(8'h51, 1'b1);
        idle(6);
        enable = 1'b1;
        idle(8);

`ifdef AXIS_TX_PACKET_MODE_EN
        // Store-and-forward hold, then oversize fallback
        wr(8'h61, 1'b0);
        wr(8'h62, 1'b0);
        idle(4);
        wr(8'h63, 1'b1);
        idle(8);
        for (int i = 0; i < 4; i++) wr(DW'(8'h70 + i), 1'b0);
        idle(8);
        wr(8'h74, 1'b1);
        idle(4);
        check("oversize_sticky", 32'(oversize_err), 32'd1);
        do_reset();
        idle(1);
`endif

        // Reset after the first beat of a 3-beat packet
        enable = 1'b1;
        tready = 1'b1;
        b0 = beats;
        wr(8'h81, 1'b0);
        wr(8'h82, 1'b0);
        wr(8'h83, 1'b1);
        for (int i = 0; i < 20 && beats == b0; i++) step();
        check("first_beat_seen", 32'(beats - b0), 32'd1);
        do_reset();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        wr(8'h91, 1'b0);
        wr(8'h92, 1'b1);
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_last  = ($urandom_range(0, 3) == 0);
            wr_data  = DW'($urandom);
            enable   = ($urandom_range(0, 7) != 0);
            tready   = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 99) == 0);
            step();
        end
        reset    = 1'b0;
        enable   = 1'b1;
        tready   = 1'b1;
        wr_valid = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
